// File: rtl/bus_fabric.sv
// Registered single-master bus fabric: decodes a request to one of NUM_SLAVES slaves, waits for ack or timeout.
// Latency: request edge -> strobe next cycle, response one cycle after slave ack; requests while busy are dropped.
module bus_fabric #(
    parameter int                           NUM_SLAVES = 4,
    parameter int                           ADDR_W     = 32,
    parameter int                           DATA_W     = 32,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE = {32'h8000_2000, 32'h8000_1000,
                                                          32'h8000_0000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK = {32'hFFFF_F000, 32'hFFFF_F000,
                                                          32'hFFFF_F000, 32'hF000_0000},
    parameter int                           TIMEOUT    = 16,
    parameter logic [DATA_W-1:0]            ERR_DATA   = 32'hDEAD_BEEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         m_rd_en_i,
    input  logic                         m_wr_en_i,
    input  logic [ADDR_W-1:0]            m_addr_i,
    input  logic [DATA_W-1:0]            m_data_i,
    output logic [DATA_W-1:0]            m_data_o,
    output logic                         m_ack_o,
    output logic                         m_err_o,
    output logic                         m_busy_o,
    output logic [NUM_SLAVES-1:0]        s_rd_en_o,
    output logic [NUM_SLAVES-1:0]        s_wr_en_o,
    output logic [ADDR_W-1:0]            s_addr_o,
    output logic [DATA_W-1:0]            s_data_o,
    input  logic [NUM_SLAVES*DATA_W-1:0] s_data_i,
    input  logic [NUM_SLAVES-1:0]        s_ack_i,
    output logic [15:0]                  err_count_o
);
    localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                rd_q, rd_d;
    logic                wr_q, wr_d;
    logic                err_q, err_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [7:0]          wait_q, wait_d;
    logic [15:0]         err_cnt_q, err_cnt_d;

    logic                dec_hit;
    logic [SEL_W-1:0]    dec_idx;
    logic                sel_ack;
    logic [DATA_W-1:0]   sel_data;
    logic                err_resp;

    // Descending scan so the lowest matching index wins.
    always_comb begin
        dec_hit = 1'b0;
        dec_idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((m_addr_i & SLAVE_MASK[i*ADDR_W +: ADDR_W]) == SLAVE_BASE[i*ADDR_W +: ADDR_W]) begin
                dec_hit = 1'b1;
                dec_idx = SEL_W'(i);
            end
        end
    end

    assign sel_ack  = s_ack_i[sel_q];
    assign sel_data = s_data_i[int'(sel_q)*DATA_W +: DATA_W];

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        rd_d      = rd_q;
        wr_d      = wr_q;
        err_d     = err_q;
        sel_d     = sel_q;
        wait_d    = wait_q;
        err_cnt_d = err_cnt_q;
        err_resp  = 1'b0;
        case (state_q)
            IDLE: begin
                if (m_rd_en_i | m_wr_en_i) begin
                    addr_d  = m_addr_i;
                    wdata_d = m_data_i;
                    rd_d    = m_rd_en_i & ~m_wr_en_i;
                    wr_d    = m_wr_en_i & ~m_rd_en_i;
                    sel_d   = dec_idx;
                    wait_d  = '0;
                    if ((m_rd_en_i & m_wr_en_i) | ~dec_hit) begin
                        err_d    = 1'b1;
                        err_resp = 1'b1;
                        state_d  = RESP;
                        if (m_rd_en_i & ~m_wr_en_i)
                            rdata_d = ERR_DATA;
                    end else begin
                        err_d   = 1'b0;
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                // An ack in the final wait cycle takes priority over the timeout.
                if (sel_ack) begin
                    err_d   = 1'b0;
                    state_d = RESP;
                    if (rd_q)
                        rdata_d = sel_data;
                end else if (wait_q == 8'(TIMEOUT - 1)) begin
                    err_d    = 1'b1;
                    err_resp = 1'b1;
                    state_d  = RESP;
                    if (rd_q)
                        rdata_d = ERR_DATA;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (err_resp && (err_cnt_q != 16'hFFFF))
            err_cnt_d = err_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            err_q     <= 1'b0;
            sel_q     <= '0;
            wait_q    <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            err_q     <= err_d;
            sel_q     <= sel_d;
            wait_q    <= wait_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    always_comb begin
        s_rd_en_o = '0;
        s_wr_en_o = '0;
        if (state_q == ACCESS) begin
            if (wr_q)
                s_wr_en_o[sel_q] = 1'b1;
            else
                s_rd_en_o[sel_q] = 1'b1;
        end
    end

    assign m_ack_o     = (state_q == RESP);
    assign m_err_o     = (state_q == RESP) & err_q;
    assign m_busy_o    = (state_q != IDLE);
    assign m_data_o    = rdata_q;
    assign s_addr_o    = addr_q;
    assign s_data_o    = wdata_q;
    assign err_count_o = err_cnt_q;
endmodule

// File: tb/tb_bus_fabric.sv
// Bench for bus_fabric: directed plan cases plus randomized transactions against an address-map reference model.
module tb_bus_fabric;
    localparam int TO = 16;
    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;
    // Slave 3 overlaps slaves 1 and 2 so that lowest-index priority is exercised.
    localparam logic [31:0] BASE [4] = '{32'h0000_0000, 32'h8000_0000, 32'h8000_1000, 32'h8000_0000};
    localparam logic [31:0] MASK [4] = '{32'hF000_0000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_0000};

    logic         clk = 1'b0;
    logic         rst;
    logic         m_rd_en, m_wr_en;
    logic [31:0]  m_addr, m_wdata, m_rdata;
    logic         m_ack, m_err, m_busy;
    logic [3:0]   s_rd_en, s_wr_en, s_ack;
    logic [31:0]  s_addr, s_wdata;
    logic [127:0] s_dat;
    logic [15:0]  err_count;

    int          tests = 0;
    int          fails = 0;
    int          exp_cnt = 0;
    logic [31:0] exp_mdata = '0;

    bus_fabric #(
        .NUM_SLAVES(4), .ADDR_W(32), .DATA_W(32),
        .SLAVE_BASE({32'h8000_0000, 32'h8000_1000, 32'h8000_0000, 32'h0000_0000}),
        .SLAVE_MASK({32'hFFFF_0000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hF000_0000}),
        .TIMEOUT(TO), .ERR_DATA(ERR_DATA)
    ) dut (
        .clk(clk), .rst(rst),
        .m_rd_en_i(m_rd_en), .m_wr_en_i(m_wr_en), .m_addr_i(m_addr), .m_data_i(m_wdata),
        .m_data_o(m_rdata), .m_ack_o(m_ack), .m_err_o(m_err), .m_busy_o(m_busy),
        .s_rd_en_o(s_rd_en), .s_wr_en_o(s_wr_en), .s_addr_o(s_addr), .s_data_o(s_wdata),
        .s_data_i(s_dat), .s_ack_i(s_ack), .err_count_o(err_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int decode(input logic [31:0] a);
        for (int i = 0; i < 4; i++)
            if ((a & MASK[i]) == BASE[i]) return i;
        return -1;
    endfunction

    // Called in an IDLE cycle; returns in the IDLE cycle following the response.
    task automatic txn(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] wdat,
                       input int ack_k, input logic [31:0] rdat, input bit busy_req);
        int       sel;
        bit       dec_err;
        bit       acked;
        logic [3:0] onehot;
        sel     = decode(addr);
        dec_err = (rd && wr) || (sel < 0);
        onehot  = (sel < 0) ? 4'b0 : 4'(1 << sel);
        acked   = 1'b0;
        m_rd_en = rd;
        m_wr_en = wr;
        m_addr  = addr;
        m_wdata = wdat;
        s_ack   = 4'($urandom);
        s_dat   = {$urandom, $urandom, $urandom, $urandom};
        step();
        m_rd_en = 1'b0;
        m_wr_en = busy_req;
        m_addr  = 32'h8000_1000;
        s_ack   = '0;
        if (!dec_err) begin
            for (int k = 1; k <= TO; k++) begin
                chk("rd_strobe", s_rd_en, rd ? onehot : 4'b0);
                chk("wr_strobe", s_wr_en, wr ? onehot : 4'b0);
                chk("ack_during_access", m_ack, 0);
                chk("busy_during_access", m_busy, 1);
                if (k == 1) begin
                    chk("s_addr", s_addr, addr);
                    chk("s_data", s_wdata, wdat);
                end
                s_dat = {$urandom, $urandom, $urandom, $urandom};
                if (k == ack_k) begin
                    s_ack = onehot | 4'($urandom);
                    s_dat[sel*32 +: 32] = rdat;
                    acked = 1'b1;
                end else begin
                    s_ack = 4'($urandom) & ~onehot;
                end
                step();
                s_ack   = '0;
                m_wr_en = 1'b0;
                if (acked) break;
            end
        end
        chk("resp_ack", m_ack, 1);
        chk("resp_err", m_err, !acked);
        chk("resp_no_strobe", {s_rd_en, s_wr_en}, 0);
        if (!acked && exp_cnt < 16'hFFFF) exp_cnt++;
        chk("err_count", err_count, exp_cnt);
        if (rd && !wr) exp_mdata = acked ? rdat : ERR_DATA;
        if (!(rd && wr)) chk("m_data", m_rdata, exp_mdata);
        m_wr_en = 1'b0;
        step();
        chk("idle_ack", m_ack, 0);
        chk("idle_busy", m_busy, 0);
        chk("idle_strobe", {s_rd_en, s_wr_en}, 0);
    endtask

    initial begin
        logic [31:0] a;
        bit          rd, wr;
        int          r, ack_k;
        rst = 1'b1; m_rd_en = 0; m_wr_en = 0; m_addr = '0; m_wdata = '0; s_ack = '0; s_dat = '0;
        step();
        step();
        chk("rst_ack", m_ack, 0);
        chk("rst_err", m_err, 0);
        chk("rst_busy", m_busy, 0);
        chk("rst_strobes", {s_rd_en, s_wr_en}, 0);
        chk("rst_mdata", m_rdata, 0);
        chk("rst_saddr", s_addr, 0);
        chk("rst_sdata", s_wdata, 0);
        chk("rst_errcnt", err_count, 0);
        rst = 1'b0;

        txn(0, 1, 32'h8000_0000, 32'h0000_00A5, 1, 32'h0, 0);
        txn(1, 0, 32'h0000_0010, 32'h0, 4, 32'h1234_5678, 0);
        txn(1, 0, 32'h4000_0000, 32'h0, 1, 32'h0, 0);
        txn(0, 1, 32'h8000_1004, 32'hCAFE_0001, 0, 32'h0, 0);
        txn(1, 0, 32'h8000_2008, 32'h0, TO, 32'h0BAD_F00D, 0);
        txn(1, 1, 32'h8000_0000, 32'h5, 1, 32'h0, 1);
        txn(0, 1, 32'h8000_1FFC, 32'h7777_0000, 2, 32'h0, 1);

        // Reset in the third ACCESS cycle discards the transaction.
        m_rd_en = 1'b1; m_addr = 32'h0000_0010;
        step();
        m_rd_en = 1'b0;
        step();
        step();
        chk("pre_rst_strobe", s_rd_en, 4'b0001);
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_cnt = 0;
        exp_mdata = '0;
        chk("mid_rst_strobes", {s_rd_en, s_wr_en}, 0);
        chk("mid_rst_busy", m_busy, 0);
        chk("mid_rst_ack", m_ack, 0);
        chk("mid_rst_errcnt", err_count, 0);
        chk("mid_rst_mdata", m_rdata, 0);
        step();
        chk("post_rst_ack", m_ack, 0);
        txn(1, 0, 32'h0000_0020, 32'h0, 1, 32'h0F0F_1234, 0);

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 5))
                0: a = {4'h0, 28'($urandom)};
                1: a = 32'h8000_0000 | 32'($urandom_range(0, 32'hFFF));
                2: a = 32'h8000_1000 | 32'($urandom_range(0, 32'hFFF));
                3: a = 32'h8000_2000 | 32'($urandom_range(0, 32'hFFF));
                4: a = 32'h8000_3000 + 32'($urandom_range(0, 32'hCFFF));
                default: a = $urandom;
            endcase
            r = $urandom_range(0, 9);
            rd = (r == 0) || (r < 5);
            wr = (r == 0) || (r >= 5);
            ack_k = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, TO);
            txn(rd, wr, a, $urandom, ack_k, $urandom, 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/bus_fabric.md
# bus_fabric

Parametrised, registered bus interconnect joining one master (the `Core` load/store port) to `NUM_SLAVES` address-decoded slaves (memory, LED peripheral, future peripherals). It replaces the fixed two-way combinational router with a per-transaction state machine. It adds slave acknowledge handshaking, a wait-state timeout, error responses for unmapped or illegal accesses, and a saturating error counter.

## Interface
- Reset: one clock; reset is synchronous and active-high.

Parameters:
- `NUM_SLAVES`, 4: number of slave ports, 1..8.
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `SLAVE_BASE`, {32'h0000_0000, 32'h8000_0000, 32'h8000_1000, 32'h8000_2000}: packed `NUM_SLAVES*ADDR_W`. Slave i occupies slice i; slave 0 is in the LSBs.
- `SLAVE_MASK`, {32'hF000_0000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000}: packed, same layout. Slave i matches when `(addr & mask_i) == base_i`.
- `TIMEOUT`, 16: maximum ACCESS cycles waiting for a slave ack, 1..255.
- `ERR_DATA`, 32'hDEAD_BEEF: read data returned on an error.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous active-high reset.
- `m_rd_en_i` in 1: master read request, sampled in IDLE only.
- `m_wr_en_i` in 1: master write request, sampled in IDLE only.
- `m_addr_i` in ADDR_W: master address.
- `m_data_i` in DATA_W: master write data.
- `m_data_o` out DATA_W: read response data, registered.
- `m_ack_o` out 1: one-cycle response pulse.
- `m_err_o` out 1: error qualifier, valid with `m_ack_o`.
- `m_busy_o` out 1: high in any state other than IDLE.
- `s_rd_en_o` out NUM_SLAVES: per-slave read strobe.
- `s_wr_en_o` out NUM_SLAVES: per-slave write strobe.
- `s_addr_o` out ADDR_W: latched address, broadcast to all slaves.
- `s_data_o` out DATA_W: latched write data, broadcast to all slaves.
- `s_data_i` in NUM_SLAVES*DATA_W: packed slave read data.
- `s_ack_i` in NUM_SLAVES: per-slave completion.
- `err_count_o` out 16: saturating count of error responses.

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE:
  - On `m_rd_en_i | m_wr_en_i`, latch the address, write data and operation, then decode.
  - The master need not hold the request after this capture.
- Decode picks the lowest-index matching slave.
- Error cases, where no slave strobe is asserted and the FSM goes to RESP with the error flag set:
  - No slave matches.
  - `m_rd_en_i & m_wr_en_i` are asserted together.
- Otherwise the FSM goes to ACCESS with the selected index latched.
- ACCESS:
  - Hold the selected `s_rd_en_o[i]` or `s_wr_en_o[i]` high for every ACCESS cycle. All other strobes are 0.
  - On `s_ack_i[sel]`, capture `s_data_i[sel]` (reads only) and go to RESP, no error.
  - The wait counter starts at 0 on entry and increments each ACCESS cycle without ack.
  - If the counter reaches `TIMEOUT - 1` with no ack, drop the strobes and go to RESP with the error flag set.
- Acks from non-selected slaves, or acks outside ACCESS, are ignored.
- RESP:
  - `m_ack_o = 1` for exactly one cycle, and `m_err_o = err`.
  - Next state is IDLE.
- Requests arriving while `m_busy_o = 1` are dropped. The master must wait for `m_ack_o`.
- `m_data_o`:
  - Updated only on read responses: slave data on success, `ERR_DATA` on error.
  - Holds its value after writes.
- `err_count_o` increments on each error response and saturates at 16'hFFFF.
- Reset values: state IDLE, all outputs 0, counters 0, latched address and data 0.

## Timing
- Request sampled at edge N (IDLE).
  - Decode error: `m_ack_o`/`m_err_o` high in cycle N+1.
  - Valid decode: strobe high in cycle N+1.
- Slave ack in ACCESS cycle k (k = 1 at the first ACCESS cycle): `m_ack_o` high in cycle N+k+1. A zero-wait slave gives a 2-cycle round trip.
- Timeout: the strobe is high for exactly `TIMEOUT` cycles, then `m_ack_o` and `m_err_o` rise in the next cycle.
- An ack arriving in the same cycle the timeout fires wins: success, no error.
- Back-to-back: the earliest next request is sampled in the cycle after `m_ack_o`, since the FSM is back in IDLE.
- `rst` asserted in any state: state is IDLE and all strobes are 0 after that edge. Any in-flight transaction is discarded with no `m_ack_o`.

## Test plan
- Write 32'h0000_00A5 to 32'h8000_0000; slave 1 acks in its first ACCESS cycle. Required: `s_wr_en_o = 4'b0010` for 1 cycle, `s_data_o = 32'hA5`, `m_ack_o` 2 cycles after the request, `m_err_o = 0`.
- Read 32'h0000_0010; slave 0 acks after 3 wait cycles with 32'h1234_5678. Required: `s_rd_en_o[0]` high for 4 cycles, `m_data_o = 32'h1234_5678`, `m_ack_o` 5 cycles after the request.
- Read 32'h4000_0000 (unmapped). Required: no strobes, `m_ack_o = m_err_o = 1` in the next cycle, `m_data_o = 32'hDEAD_BEEF`, `err_count_o = 1`.
- Write to slave 2 with no ack, `TIMEOUT = 16`. Required: `s_wr_en_o[2]` high for exactly 16 cycles, then an error response and `err_count_o` incremented.
- Assert `rst` during the third ACCESS cycle. Required: strobes 0 and `m_busy_o = 0` after the edge, no `m_ack_o`; a following zero-wait read completes normally.
- Simultaneous `m_rd_en_i`/`m_wr_en_i`, plus a second request while busy. Required: the first gets an error response; the second is ignored with no strobe.
